// File: rtl/fsm_state_coverage_if.sv
// Bus bundle between a monitored FSM environment (master) and the state-coverage monitor (slave).
interface fsm_state_coverage_if #(
    parameter int STATE_W = 2,
    parameter int CNT_W   = 16
);
    localparam int NS = 1 << STATE_W;

    logic [STATE_W-1:0] state_in;
    logic               state_vld;
    logic               clr;
    logic [NS-1:0]      visited;
    logic [NS-1:0]      unvisited;
    logic               illegal_seen;
    logic [STATE_W-1:0] illegal_state;
    logic [CNT_W-1:0]   trans_cnt;
    logic               rd_req;
    logic [STATE_W-1:0] rd_idx;
    logic               rd_busy;
    logic               rd_vld;
    logic [CNT_W-1:0]   rd_visits;
    logic               stuck;

    modport master (
        output state_in, state_vld, clr, rd_req, rd_idx,
        input  visited, unvisited, illegal_seen, illegal_state, trans_cnt,
        input  rd_busy, rd_vld, rd_visits, stuck
    );

    modport slave (
        input  state_in, state_vld, clr, rd_req, rd_idx,
        output visited, unvisited, illegal_seen, illegal_state, trans_cnt,
        output rd_busy, rd_vld, rd_visits, stuck
    );
endinterface

// File: rtl/fsm_state_coverage.sv
// Runtime state-coverage monitor for a design FSM state bus: visited/illegal tracking,
// transition and per-state visit counters, visit-count readout. Optional stuck watchdog via STUCK_WD_EN.
module fsm_state_coverage #(
    parameter int                         STATE_W     = 2,
    parameter int                         CNT_W       = 16,
    parameter logic [(1<<STATE_W)-1:0]    LEGAL_MASK  = 4'b0111,
    parameter int                         STUCK_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    fsm_state_coverage_if.slave  mon
);
    localparam int               NS      = 1 << STATE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CAPT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    logic [NS-1:0]      visited_q, visited_d;
    logic               illegal_seen_q, illegal_seen_d;
    logic [STATE_W-1:0] illegal_state_q, illegal_state_d;
    logic [CNT_W-1:0]   trans_cnt_q, trans_cnt_d;
    logic [CNT_W-1:0]   visit_cnt_q [NS];
    logic [CNT_W-1:0]   visit_cnt_d [NS];
    logic [STATE_W-1:0] prev_state_q, prev_state_d;
    logic               prev_vld_q, prev_vld_d;

    rd_state_t          rd_state_q, rd_state_d;
    logic [STATE_W-1:0] rd_idx_q, rd_idx_d;
    logic               rd_busy_q, rd_busy_d;
    logic               rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]   rd_visits_q, rd_visits_d;

    logic               legal_s;
    assign legal_s = LEGAL_MASK[mon.state_in];

    // Statistics update: clr discards the same-cycle sample
    always_comb begin
        visited_d       = visited_q;
        illegal_seen_d  = illegal_seen_q;
        illegal_state_d = illegal_state_q;
        trans_cnt_d     = trans_cnt_q;
        visit_cnt_d     = visit_cnt_q;
        prev_state_d    = prev_state_q;
        prev_vld_d      = prev_vld_q;
        if (mon.clr) begin
            visited_d       = {NS{1'b0}};
            illegal_seen_d  = 1'b0;
            illegal_state_d = {STATE_W{1'b0}};
            trans_cnt_d     = {CNT_W{1'b0}};
            visit_cnt_d     = '{default: {CNT_W{1'b0}}};
            prev_state_d    = {STATE_W{1'b0}};
            prev_vld_d      = 1'b0;
        end else if (mon.state_vld && legal_s) begin
            visited_d[mon.state_in] = 1'b1;
            if (visit_cnt_q[mon.state_in] != CNT_MAX) begin
                visit_cnt_d[mon.state_in] = visit_cnt_q[mon.state_in] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                visit_cnt_d[mon.state_in] = CNT_MAX;
            end
            if (prev_vld_q && (mon.state_in != prev_state_q) && (trans_cnt_q != CNT_MAX)) begin
                trans_cnt_d = trans_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                trans_cnt_d = trans_cnt_q;
            end
            prev_state_d = mon.state_in;
            prev_vld_d   = 1'b1;
        end else if (mon.state_vld) begin
            illegal_seen_d = 1'b1;
            if (!illegal_seen_q) begin
                illegal_state_d = mon.state_in;
            end else begin
                illegal_state_d = illegal_state_q;
            end
            prev_vld_d = 1'b0;
        end else begin
            prev_vld_d = prev_vld_q;
        end
    end

    // Read FSM: capture sees the pre-update counter value, zero if cleared this cycle
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_idx_d    = rd_idx_q;
        rd_visits_d = rd_visits_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (mon.rd_req) begin
                    rd_idx_d   = mon.rd_idx;
                    rd_state_d = RD_CAPT;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_CAPT: begin
                if (mon.clr || !LEGAL_MASK[rd_idx_q]) begin
                    rd_visits_d = {CNT_W{1'b0}};
                end else begin
                    rd_visits_d = visit_cnt_q[rd_idx_q];
                end
                rd_state_d = RD_RESP;
            end
            RD_RESP: rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
        rd_busy_d = (rd_state_d != RD_IDLE);
        rd_vld_d  = (rd_state_d == RD_RESP);
    end

    // Statistics and read-path registers
    always_ff @(posedge clk) begin
        if (rst) begin
            visited_q       <= {NS{1'b0}};
            illegal_seen_q  <= 1'b0;
            illegal_state_q <= {STATE_W{1'b0}};
            trans_cnt_q     <= {CNT_W{1'b0}};
            visit_cnt_q     <= '{default: {CNT_W{1'b0}}};
            prev_state_q    <= {STATE_W{1'b0}};
            prev_vld_q      <= 1'b0;
            rd_state_q      <= RD_IDLE;
            rd_idx_q        <= {STATE_W{1'b0}};
            rd_busy_q       <= 1'b0;
            rd_vld_q        <= 1'b0;
            rd_visits_q     <= {CNT_W{1'b0}};
        end else begin
            visited_q       <= visited_d;
            illegal_seen_q  <= illegal_seen_d;
            illegal_state_q <= illegal_state_d;
            trans_cnt_q     <= trans_cnt_d;
            visit_cnt_q     <= visit_cnt_d;
            prev_state_q    <= prev_state_d;
            prev_vld_q      <= prev_vld_d;
            rd_state_q      <= rd_state_d;
            rd_idx_q        <= rd_idx_d;
            rd_busy_q       <= rd_busy_d;
            rd_vld_q        <= rd_vld_d;
            rd_visits_q     <= rd_visits_d;
        end
    end

`ifdef STUCK_WD_EN
    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LIMIT);
    localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(STUCK_LIMIT - 1);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             stuck_q, stuck_d;

    // Repeat counter: counts same-state samples after the entry sample
    always_comb begin
        run_cnt_d = run_cnt_q;
        stuck_d   = stuck_q;
        if (mon.clr) begin
            run_cnt_d = {RUN_W{1'b0}};
            stuck_d   = 1'b0;
        end else if (mon.state_vld && legal_s) begin
            if (prev_vld_q && (mon.state_in == prev_state_q)) begin
                if (run_cnt_q != RUN_MAX) begin
                    run_cnt_d = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
                end else begin
                    run_cnt_d = RUN_MAX;
                end
            end else begin
                run_cnt_d = {RUN_W{1'b0}};
            end
            stuck_d = (run_cnt_d >= RUN_HIT);
        end else if (mon.state_vld) begin
            run_cnt_d = {RUN_W{1'b0}};
            stuck_d   = 1'b0;
        end else begin
            stuck_d = stuck_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= {RUN_W{1'b0}};
            stuck_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign mon.stuck = stuck_q;
`else
    assign mon.stuck = 1'b0;
`endif

    assign mon.visited       = visited_q;
    assign mon.unvisited     = LEGAL_MASK & ~visited_q;
    assign mon.illegal_seen  = illegal_seen_q;
    assign mon.illegal_state = illegal_state_q;
    assign mon.trans_cnt     = trans_cnt_q;
    assign mon.rd_busy       = rd_busy_q;
    assign mon.rd_vld        = rd_vld_q;
    assign mon.rd_visits     = rd_visits_q;

endmodule
